// File: rtl/icache_controller.sv
// Direct-mapped instruction cache controller.
// Serves 32-bit words from 128-bit lines. A hit returns the word in the same cycle.
// On a miss, fetch stalls while one block is read from instruction memory and
// written into the line. Saturating hit and miss counters measure performance.
module icache_controller #(
  parameter int unsigned LINES   = 8,
  parameter int unsigned INDEX_W = 3,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic [31:0]      PC_ADDRESS,
  input  logic             PC_VALID,
  output logic [31:0]      INSTRUCTION,
  output logic             CPU_BUSYWAIT,
  output logic             MEM_READ,
  output logic [27:0]      MEM_BLOCK_ADDRESS,
  input  logic [127:0]     MEM_READDATA,
  input  logic             MEM_BUSYWAIT,
  output logic [CNT_W-1:0] HIT_COUNT,
  output logic [CNT_W-1:0] MISS_COUNT
);

  localparam int unsigned TAG_W = 28 - INDEX_W;

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StMemRead = 2'd1;
  localparam logic [1:0] StUpdate  = 2'd2;

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [1:0]         state_q, state_d;
  logic [LINES-1:0]   valid_q;
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [127:0]       data_q [LINES];
  logic [27:0]        miss_addr_q;
  logic [CNT_W-1:0]   hit_cnt_q, miss_cnt_q;

  logic [INDEX_W-1:0] pc_index;
  logic [TAG_W-1:0]   pc_tag;
  logic [1:0]         pc_word;
  logic [INDEX_W-1:0] fill_index;
  logic [127:0]       line_data;
  logic [31:0]        line_word;
  logic               in_idle;
  logic               hit;
  logic               miss;
  logic               fill;
  logic               unused_pc;

  // Byte offset within the word is irrelevant for instruction fetch.
  assign unused_pc = ^PC_ADDRESS[1:0];

  assign pc_word    = PC_ADDRESS[3:2];
  assign pc_index   = PC_ADDRESS[4 +: INDEX_W];
  assign pc_tag     = PC_ADDRESS[31 -: TAG_W];
  assign fill_index = miss_addr_q[INDEX_W-1:0];

  // Lookup is only meaningful in idle. The valid bit gates the tag compare, so
  // unreset tag/data contents never reach the outputs.
  assign in_idle = (state_q == StIdle);
  assign hit     = in_idle & PC_VALID & valid_q[pc_index] & (tag_q[pc_index] == pc_tag);
  assign miss    = in_idle & PC_VALID & ~hit;
  assign fill    = (state_q == StMemRead) & ~MEM_BUSYWAIT;

  // Select the addressed word of the indexed line; zero unless it is a hit.
  always_comb begin
    line_data = data_q[pc_index];
    line_word = 32'h0;
    unique case (pc_word)
      2'd0:    line_word = line_data[31:0];
      2'd1:    line_word = line_data[63:32];
      2'd2:    line_word = line_data[95:64];
      default: line_word = line_data[127:96];
    endcase
    INSTRUCTION = hit ? line_word : 32'h0;
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_d      = state_q;
    CPU_BUSYWAIT = 1'b0;
    MEM_READ     = 1'b0;
    case (state_q)
      StIdle: begin
        CPU_BUSYWAIT = miss;
        if (miss) state_d = StMemRead;
      end
      StMemRead: begin
        MEM_READ     = 1'b1;
        CPU_BUSYWAIT = 1'b1;
        if (!MEM_BUSYWAIT) state_d = StUpdate;
      end
      StUpdate: begin
        CPU_BUSYWAIT = 1'b1;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign MEM_BLOCK_ADDRESS = miss_addr_q;
  assign HIT_COUNT         = hit_cnt_q;
  assign MISS_COUNT        = miss_cnt_q;

  // Control state, valid bits, miss address and counters, all cleared by reset.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= StIdle;
      valid_q     <= '0;
      miss_addr_q <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      state_q <= state_d;
      if (miss) begin
        miss_addr_q <= PC_ADDRESS[31:4];
        if (miss_cnt_q != CntMax) miss_cnt_q <= miss_cnt_q + CntOne;
      end
      if (hit && (hit_cnt_q != CntMax)) hit_cnt_q <= hit_cnt_q + CntOne;
      if (fill) valid_q[fill_index] <= 1'b1;
    end
  end

  // Tag and data storage; filled from the latched miss address, never reset.
  always_ff @(posedge CLOCK) begin
    if (fill) begin
      tag_q[fill_index]  <= miss_addr_q[27 -: TAG_W];
      data_q[fill_index] <= MEM_READDATA;
    end
  end

endmodule
